// File: rtl/pixel_window_steer.sv
// pixel_window_steer
//   Two-stage valid/ready pipeline between the line buffers and the
//   neighbourhood-operator datapath. Each accepted input word is joined with the
//   previously accepted word to form a 2*LANES-pixel window {current, previous}.
//   The window is then steered by a per-beat offset into 2*LANES output lanes.
//   Stage 1 captures the window and the beat controls. Stage 2 steers the window
//   into m_data.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   flush    synchronous clear of both stages and the held word; overrides everything else
//   s_valid  input beat valid
//   s_ready  input beat accepted when s_valid && s_ready
//   s_data   LANES pixels; lane 0 is in the LSBs and is the leftmost pixel in the image
//   s_sol    start of line: lower window pixels replicate s_data lane 0
//   s_sel    steer offset for the beat
//   s_mode   00/11 rotate, 01 edge-replicate shift, 10 zero-fill shift
//   m_valid  output beat valid
//   m_ready  downstream accept
//   m_data   steered window, 2*LANES pixels, lane 0 in the LSBs
//   m_sol    s_sol of the beat that produced m_data
module pixel_window_steer #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  localparam int SEL_W = $clog2(2*LANES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [LANES*PIX_W-1:0]     s_data,
  input  logic                       s_sol,
  input  logic [SEL_W-1:0]           s_sel,
  input  logic [1:0]                 s_mode,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [2*LANES*PIX_W-1:0]   m_data,
  output logic                       m_sol
);

  localparam int N = 2*LANES;
  localparam logic [1:0] MODE_EDGE = 2'b01;
  localparam logic [1:0] MODE_ZERO = 2'b10;

  logic [LANES*PIX_W-1:0] held_reg;
  logic [N*PIX_W-1:0]     win_next;
  logic [N*PIX_W-1:0]     win1_reg;
  logic [SEL_W-1:0]       sel1_reg;
  logic [1:0]             mode1_reg;
  logic                   sol1_reg;
  logic                   v1_reg;
  logic [N*PIX_W-1:0]     steer_data;
  logic                   en1;
  logic                   en2;

  // Stage 2 may advance when its slot is empty or being drained. Stage 1 may
  // advance when it is empty or stage 2 takes its content.
  assign en2     = !m_valid || m_ready;
  assign en1     = !v1_reg || en2;
  assign s_ready = en1;

  // Window assembly: the upper half is always the incoming word. At the start of
  // a line the lower half replicates the left edge pixel instead of the stale
  // word from the previous line.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_win
      assign win_next[gi*PIX_W +: PIX_W] =
        s_sol ? s_data[PIX_W-1:0] : held_reg[gi*PIX_W +: PIX_W];
      assign win_next[(gi+LANES)*PIX_W +: PIX_W] = s_data[gi*PIX_W +: PIX_W];
    end
  endgenerate

  // Steering: output lane gi takes window pixel k = gi + sel. N is a power of
  // two, so bit SEL_W of k flags k >= N. The low SEL_W bits of k are k mod N.
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [SEL_W:0]   k;
      logic [PIX_W-1:0] pix;

      assign k = {1'b0, sel1_reg} + (SEL_W+1)'(gi);

      always_comb begin
        pix = win1_reg[k[SEL_W-1:0]*PIX_W +: PIX_W];
        if (k[SEL_W]) begin
          case (mode1_reg)
            MODE_EDGE: pix = win1_reg[(N-1)*PIX_W +: PIX_W];
            MODE_ZERO: pix = '0;
            default:   ;
          endcase
        end
      end

      assign steer_data[gi*PIX_W +: PIX_W] = pix;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_reg  <= '0;
      win1_reg  <= '0;
      sel1_reg  <= '0;
      mode1_reg <= '0;
      sol1_reg  <= 1'b0;
      v1_reg    <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_sol     <= 1'b0;
    end else if (flush) begin
      // m_data and m_sol keep their last values. Only the valids and the held word clear.
      v1_reg   <= 1'b0;
      m_valid  <= 1'b0;
      held_reg <= '0;
    end else begin
      if (en1) begin
        v1_reg <= s_valid;
        if (s_valid) begin
          win1_reg  <= win_next;
          sel1_reg  <= s_sel;
          mode1_reg <= s_mode;
          sol1_reg  <= s_sol;
          held_reg  <= s_data;
        end
      end
      if (en2) begin
        m_valid <= v1_reg;
        // Load only real beats so that m_data does not churn while idle.
        if (v1_reg) begin
          m_data <= steer_data;
          m_sol  <= sol1_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_window_steer.sv
// tb_pixel_window_steer
//   Directed and randomised stimulus for pixel_window_steer with LANES=4 and
//   PIX_W=8. A reference model of the window/steer rules predicts every output
//   beat in order. Literal expectations pin the individual steering cases.
module tb_pixel_window_steer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_sol;
  logic [2:0]  s_sel;
  logic [1:0]  s_mode;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_sol;

  int checks   = 0;
  int failures = 0;

  logic [64:0] exp_q[$];
  logic [31:0] h_model;
  logic        prev_stall;
  logic [63:0] prev_data;
  logic        prev_sol;
  logic        post_flush;

  always #5 clk = ~clk;

  pixel_window_steer #(.PIX_W(8), .LANES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_sol   (s_sol),
    .s_sel   (s_sel),
    .s_mode  (s_mode),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_sol   (m_sol)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Window pixels per the steering rules: lower half is the previous word, or
  // the left-edge pixel replicated at start of line. Upper half is the new word.
  function automatic logic [63:0] model(input logic [31:0] d, input logic [31:0] h,
                                        input logic sol, input logic [2:0] sel,
                                        input logic [1:0] mode);
    logic [7:0]  p[8];
    logic [63:0] r;
    int          k;
    for (int j = 0; j < 4; j++) begin
      p[j]   = sol ? d[7:0] : h[8*j +: 8];
      p[4+j] = d[8*j +: 8];
    end
    r = '0;
    for (int i = 0; i < 8; i++) begin
      k = i + int'(sel);
      if (mode == 2'b01)      r[8*i +: 8] = (k > 7) ? p[7] : p[k];
      else if (mode == 2'b10) r[8*i +: 8] = (k > 7) ? 8'h00 : p[k];
      else                    r[8*i +: 8] = p[k % 8];
    end
    return r;
  endfunction

  // Scoreboard: all handshakes are judged at the falling edge, when the inputs
  // and outputs that the next rising edge will act on are stable.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
      h_model    = '0;
      prev_stall = 1'b0;
      post_flush = rst_n && flush;
    end else begin
      if (post_flush) chk("flush_mvalid", {63'b0, m_valid}, 64'd0);
      post_flush = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", {63'b0, m_valid}, 64'd1);
        chk("stall_data", m_data, prev_data);
        chk("stall_sol", {63'b0, m_sol}, {63'b0, prev_sol});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out actual=%h expected=none", m_data);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          chk("sb_data", m_data, e[63:0]);
          chk("sb_sol", {63'b0, m_sol}, {63'b0, e[64]});
        end
      end
      if (s_valid && s_ready) begin
        exp_q.push_back({s_sol, model(s_data, h_model, s_sol, s_sel, s_mode)});
        h_model = s_data;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_sol   = m_sol;
    end
  end

  task automatic send(input logic [31:0] d, input logic sol, input logic [2:0] sel,
                      input logic [1:0] mode);
    s_valid = 1'b1;
    s_data  = d;
    s_sol   = sol;
    s_sel   = sel;
    s_mode  = mode;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic run_ab(input logic [1:0] mode, input logic [63:0] exp, input string name);
    send(32'h44332211, 1'b1, 3'd0, 2'b00);
    send(32'h88776655, 1'b0, 3'd3, mode);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, {63'b0, m_valid}, 64'd1);
    chk(name, m_data, exp);
  endtask

  int sent;
  int cyc;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; s_sol = 1'b0;
    s_sel = '0; s_mode = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvalid", {63'b0, m_valid}, 64'd0);
    chk("rst_mdata", m_data, 64'd0);
    chk("rst_msol", {63'b0, m_sol}, 64'd0);
    chk("rst_sready", {63'b0, s_ready}, 64'd1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_mvalid", {63'b0, m_valid}, 64'd0);
    chk("idle_sready", {63'b0, s_ready}, 64'd1);

    m_ready = 1'b1;
    run_ab(2'b00, 64'h3322118877665544, "rotate");
    run_ab(2'b01, 64'h8888888877665544, "edge");
    run_ab(2'b10, 64'h0000008877665544, "zero");
    run_ab(2'b11, 64'h3322118877665544, "mode3");

    send(32'h04030201, 1'b1, 3'd2, 2'b00);
    @(posedge clk);
    #1;
    chk("sol_data", m_data, 64'h0101040302010101);
    chk("sol_flag", {63'b0, m_sol}, 64'd1);

    // Async reset mid-stream with a full pipe.
    m_ready = 1'b0;
    send(32'hAABBCCDD, 1'b0, 3'd1, 2'b01);
    send(32'h11223344, 1'b0, 3'd5, 2'b10);
    chk("full_sready", {63'b0, s_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_mvalid", {63'b0, m_valid}, 64'd0);
    chk("midrst_mdata", m_data, 64'd0);
    chk("midrst_sready", {63'b0, s_ready}, 64'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Flush with a full pipe. The beat offered during the flush must vanish.
    m_ready = 1'b0;
    send(32'h04030201, 1'b1, 3'd2, 2'b00);
    send(32'h55667788, 1'b0, 3'd0, 2'b00);
    chk("stall_sready", {63'b0, s_ready}, 64'd0);
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    flush = 1'b0;
    s_valid = 1'b0;
    chk("flush_mvalid_now", {63'b0, m_valid}, 64'd0);
    chk("flush_mdata_hold", m_data, 64'h0101040302010101);
    m_ready = 1'b1;
    send(32'h88776655, 1'b0, 3'd0, 2'b00);
    @(posedge clk);
    #1;
    chk("post_flush_h0", m_data, 64'h8877665500000000);

    // Random valid/ready stalls.
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = $urandom;
      s_sol   = ($urandom_range(0, 3) == 0);
      s_sel   = 3'($urandom);
      s_mode  = 2'($urandom);
      m_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (s_valid && s_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("random_sent", 64'(sent), 64'd1000);

    s_valid = 1'b0;
    m_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_mvalid", {63'b0, m_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
